// File: rtl/vga_scanout.sv
// VGA raster timing generator with pixel/line replication and a one-line
// cache, so a host can stream a low-resolution frame one pixel at a time.
module vga_scanout #(
  parameter int GRAY_W   = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int LINE_MAX = 160,
  parameter int DIV_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  pixel_div,
  input  logic [DIV_W-1:0]  line_rep,
  input  logic [GRAY_W-1:0] frame_pixel_in,
  output logic              h_sync_out,
  output logic              v_sync_out,
  output logic [GRAY_W-1:0] gray_out,
  output logic              frame_next_pixel_out,
  output logic              frame_reset_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int X_MAX   = (H_ACTIVE > LINE_MAX) ? H_ACTIVE : LINE_MAX;
  localparam int X_W     = $clog2(X_MAX + 1);
  localparam int LW      = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_FIRST = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_FIRST = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [X_W-1:0] X_LIMIT  = X_W'(LINE_MAX);
  localparam logic           HS_ON    = (HS_POL != 0);
  localparam logic           VS_ON    = (VS_POL != 0);

  logic [H_W-1:0]    h_cnt;
  logic [V_W-1:0]    v_cnt;
  logic [DIV_W-1:0]  div_l;
  logic [DIV_W-1:0]  rep_l;
  logic [DIV_W-1:0]  d_cnt;
  logic [DIV_W-1:0]  r_cnt;
  logic [X_W-1:0]    x_src;
  logic [GRAY_W-1:0] line_buf [LINE_MAX];

  logic           h_wrap;
  logic           frame_end;
  logic           active;
  logic           fetch_slot;
  logic           in_buf;
  logic [LW-1:0]  buf_idx;

  always_comb begin
    h_wrap     = (h_cnt == H_LAST);
    frame_end  = h_wrap && (v_cnt == V_LAST);
    active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    fetch_slot = active && (r_cnt == '0) && (d_cnt == '0);
    in_buf     = (x_src < X_LIMIT);
    buf_idx    = x_src[LW-1:0];
  end

  // Raster counters, per-frame config snapshot and replication counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      div_l <= '0;
      rep_l <= '0;
      d_cnt <= '0;
      x_src <= '0;
      r_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap)
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      if (frame_end) begin
        div_l <= pixel_div;
        rep_l <= line_rep;
      end
      if (h_wrap) begin
        d_cnt <= '0;
        x_src <= '0;
      end else if (h_cnt < H_ACT) begin
        if (d_cnt == div_l) begin
          d_cnt <= '0;
          x_src <= x_src + 1'b1;
        end else begin
          d_cnt <= d_cnt + 1'b1;
        end
      end
      if (frame_end)
        r_cnt <= '0;
      else if (h_wrap && (v_cnt < V_ACT))
        r_cnt <= (r_cnt == rep_l) ? '0 : r_cnt + 1'b1;
    end
  end

  // Output registers: one clock behind the counters they are decoded from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sync_out           <= ~HS_ON;
      v_sync_out           <= ~VS_ON;
      gray_out             <= '0;
      frame_next_pixel_out <= 1'b0;
      frame_reset_out      <= 1'b0;
    end else begin
      h_sync_out           <= (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) ? HS_ON : ~HS_ON;
      v_sync_out           <= (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) ? VS_ON : ~VS_ON;
      frame_reset_out      <= (h_cnt == '0) && (v_cnt == VS_FIRST);
      frame_next_pixel_out <= fetch_slot;
      if (!active)
        gray_out <= '0;
      else if (r_cnt == '0) begin
        if (d_cnt == '0)
          gray_out <= frame_pixel_in;
      end else
        gray_out <= in_buf ? line_buf[buf_idx] : '0;
    end
  end

  // The line cache is deliberately not reset; repeat lines only read slots
  // written by the fetch line of the same group.
  always_ff @(posedge clk) begin
    if (fetch_slot && in_buf)
      line_buf[buf_idx] <= frame_pixel_in;
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized bench for vga_scanout: a host model streams random pixels and a
// frame-position reference model predicts every output on every clock.
module tb_vga_scanout;

  localparam int GW = 4;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int LM = 4;
  localparam int DW = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] pixel_div;
  logic [DW-1:0] line_rep;
  logic [GW-1:0] frame_pixel_in;
  logic          h_sync_out;
  logic          v_sync_out;
  logic [GW-1:0] gray_out;
  logic          frame_next_pixel_out;
  logic          frame_reset_out;

  vga_scanout #(
    .GRAY_W(GW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .LINE_MAX(LM), .DIV_W(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pixel_div(pixel_div),
    .line_rep(line_rep),
    .frame_pixel_in(frame_pixel_in),
    .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out),
    .gray_out(gray_out),
    .frame_next_pixel_out(frame_next_pixel_out),
    .frame_reset_out(frame_reset_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int t = 0;
  int div_m = 0;
  int rep_m = 0;
  int host_idx = 0;
  logic [GW-1:0] pix_mem [64];
  int unsigned div_tab [6] = '{0, 1, 1, 0, 2, 3};
  int unsigned rep_tab [6] = '{0, 0, 1, 1, 3, 0};

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h frame_pos=%0d", tag, obs, expv, t);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_gray", gray_out, 4'd0);
    checkOutput("rst_hsync", {3'b0, h_sync_out}, 4'd1);
    checkOutput("rst_vsync", {3'b0, v_sync_out}, 4'd1);
    checkOutput("rst_next", {3'b0, frame_next_pixel_out}, 4'd0);
    checkOutput("rst_freset", {3'b0, frame_reset_out}, 4'd0);
  endtask

  task automatic refillPixels();
    for (int i = 0; i < 64; i++) pix_mem[i] = 4'($urandom);
  endtask

  // One clock: predict outputs from the pre-edge frame position, clock, compare,
  // then let the host react to the pulses it just saw.
  task automatic applyStimulus();
    int h, v, x, p, k, r;
    logic e_hs, e_vs, e_fr, e_np;
    logic [GW-1:0] e_g;
    h = t % HT;
    v = t / HT;
    e_hs = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
    e_vs = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
    e_fr = (h == 0 && v == VA + VF);
    e_np = 1'b0;
    e_g  = '0;
    if (h < HA && v < VA) begin
      p = (HA + div_m) / (div_m + 1);
      x = h / (div_m + 1);
      k = v / (rep_m + 1);
      r = v % (rep_m + 1);
      e_np = (r == 0) && (h % (div_m + 1) == 0);
      e_g  = (r == 0 || x < LM) ? pix_mem[(k * p + x) % 64] : '0;
    end
    if (h == HT - 1 && v == VT - 1) begin
      div_m = int'(pixel_div);
      rep_m = int'(line_rep);
    end
    t = (t + 1) % FRAME;
    @(posedge clk);
    #1;
    checkOutput("gray", gray_out, e_g);
    checkOutput("hsync", {3'b0, h_sync_out}, {3'b0, e_hs});
    checkOutput("vsync", {3'b0, v_sync_out}, {3'b0, e_vs});
    checkOutput("next_pixel", {3'b0, frame_next_pixel_out}, {3'b0, e_np});
    checkOutput("frame_reset", {3'b0, frame_reset_out}, {3'b0, e_fr});
    if (frame_reset_out) begin
      host_idx = 0;
      refillPixels();
    end else if (frame_next_pixel_out) begin
      host_idx = (host_idx + 1) % 64;
    end
    frame_pixel_in = pix_mem[host_idx];
  endtask

  task automatic restartModel();
    t = 0;
    div_m = 0;
    rep_m = 0;
    host_idx = 0;
    frame_pixel_in = pix_mem[0];
  endtask

  initial begin
    rst_n = 1'b0;
    pixel_div = '0;
    line_rep = '0;
    for (int i = 0; i < 64; i++) pix_mem[i] = 4'(i);
    frame_pixel_in = pix_mem[0];
    repeat (2) @(posedge clk);
    #1;
    checkReset();
    rst_n = 1'b1;
    restartModel();

    // Directed configurations first, then random ones with mid-frame changes.
    for (int f = 0; f < 14; f++) begin
      if (f < 6) begin
        pixel_div = 4'(div_tab[f]);
        line_rep  = 4'(rep_tab[f]);
      end else begin
        pixel_div = 4'($urandom_range(0, 9));
        line_rep  = 4'($urandom_range(0, 5));
      end
      for (int s = 0; s < FRAME; s++) begin
        if (f >= 6 && s == 30) pixel_div = 4'($urandom_range(0, 9));
        applyStimulus();
      end
    end

    // Asynchronous reset in the middle of an active line.
    pixel_div = 4'd1;
    line_rep  = 4'd1;
    for (int s = 0; s < 47; s++) applyStimulus();
    #2;
    rst_n = 1'b0;
    #1;
    checkReset();
    @(posedge clk);
    #1;
    checkReset();
    rst_n = 1'b1;
    restartModel();
    for (int s = 0; s < 3 * FRAME; s++) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter GRAY_W, default 4, gray output and pixel input width in bits.
REQ-002 Parameters H_ACTIVE, H_FP, H_SYNC, H_BP, defaults 640, 16, 96, 48, horizontal timing in clocks.
REQ-003 Parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, vertical timing in lines.
REQ-004 Parameters HS_POL and VS_POL, default 0 each, sync active level (0 = active-low).
REQ-005 Parameter LINE_MAX, default 160, line buffer depth in source pixels.
REQ-006 Parameter DIV_W, default 4, width of the pixel_div and line_rep inputs.
REQ-007 Port clk, input, 1, the single clock.
REQ-008 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-009 Port pixel_div, input, DIV_W, horizontal repeat: each source pixel is shown for pixel_div+1 clocks.
REQ-010 Port line_rep, input, DIV_W, vertical repeat: each source line is shown line_rep+1 times.
REQ-011 Port frame_pixel_in, input, GRAY_W, current source pixel presented by the host.
REQ-012 Port h_sync_out and v_sync_out, outputs, 1 each, sync signals.
REQ-013 Port gray_out, output, GRAY_W, pixel intensity.
REQ-014 Port frame_next_pixel_out, output, 1, one-clock pulse that tells the host to advance to the next pixel.
REQ-015 Port frame_reset_out, output, 1, one-clock pulse that tells the host to rewind to pixel 0.

Function
REQ-016 h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt increments on each h wrap, counts 0..V_TOTAL-1 and wraps; H_TOTAL and V_TOTAL are the sums of their four timing parameters.
REQ-017 All outputs are registered, with exactly one clock of latency from counter state to pin.
REQ-018 Sync is active while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (horizontal), or v_cnt in the equivalent vertical range (vertical), at the level set by the POL parameter.
REQ-019 Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; outside it gray_out=0 and frame_next_pixel_out=0.
REQ-020 Config latch: pixel_div and line_rep are captured only on the last clock of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1); mid-frame changes take effect the next frame.
REQ-021 Slot counter d runs 0..div_l and source index x_src increments when d wraps; both clear at the start of each line.
REQ-022 Repeat counter r clears at frame start, increments at the end of each active line, and wraps to 0 after reaching rep_l.
REQ-023 Fetch line (r=0), d=0: frame_pixel_in is sampled into the gray register; if x_src<LINE_MAX it is also written to buffer[x_src]; frame_next_pixel_out pulses.
REQ-024 Fetch line, d>0: gray_out holds the sampled value and no pulse occurs.
REQ-025 Repeat line (r>0): gray_out=buffer[x_src], or 0 when x_src>=LINE_MAX; frame_next_pixel_out stays 0.
REQ-026 Host contract: frame_pixel_in must be valid at pixel 0 by the first active clock, and must hold the next pixel within div_l+1 clocks after each pulse.
REQ-027 frame_reset_out pulses once per frame, on the first clock of vertical sync (h_cnt=0, v_cnt=V_ACTIVE+V_FP).
REQ-028 Pulses per fetch line = ceil(H_ACTIVE/(div_l+1)); a trailing partial slot is truncated at H_ACTIVE.

Reset
REQ-029 While rst_n=0: all counters and latched config are 0, syncs are inactive, gray_out=0, and both frame pulses are 0; the effect is immediate, including mid-line.
REQ-030 After release, the first frame uses div_l=0 and rep_l=0; line buffer contents are not reset.

Verification (H 8/2/2/2, V 4/1/1/1, LINE_MAX=4, GRAY_W=4)
REQ-031 Reset asserted -> gray_out=0, h_sync_out=1, v_sync_out=1, no pulses; release -> h_sync_out low for clocks 11-12 of each line (1-based, including the output latency).
REQ-032 div=0, rep=0, host ramp 0..7 -> 8 pulses per line, 32 per frame, gray_out follows 0..7, one frame_reset_out pulse per 98 clocks.
REQ-033 div=1, rep=0 -> 4 pulses per line, each gray value held 2 clocks.
REQ-034 div=1, rep=1, lines A,B,C,D -> lines 0 and 2 fetch 4 pixels each; lines 1 and 3 replay them from the buffer with no pulses.
REQ-035 div=0, rep=1 -> repeat-line pixels 4..7 are gray 0; pixels 0..3 match the fetch line.
REQ-036 pixel_div changed mid-frame -> the current frame is unchanged and the new value applies from the next frame; rst_n pulsed mid-line -> outputs reset instantly and timing restarts at h=0, v=0.
